// File: rtl/instr2cache_bridge.sv
`default_nettype none
// ============================================================================
// Module   : instr2cache_bridge
// Brief    : Bridges the core instruction fetch port to the tile I$.
//            Tracks in-flight fetches, drops stale responses after a flush,
//            answers misaligned fetches locally with an error and optionally
//            registers the response path.
// Revision : 1.0 - initial release
// ============================================================================
module instr2cache_bridge #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter bit REG_RSP         = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    // core fetch port
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,
    // instruction cache port
    output logic              cache_req_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    input  logic              cache_gnt_i,
    input  logic              cache_rvalid_i,
    input  logic [DATA_W-1:0] cache_rdata_i,
    input  logic              cache_rerror_i,
    // status
    output logic              busy_o
);

    // Byte-offset bits that must be zero for an aligned fetch.
    localparam int c_OFF_W = $clog2(DATA_W / 8);
    // Counter wide enough to hold 0..MAX_OUTSTANDING.
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_OUTSTANDING);

    logic [c_CNT_W-1:0] r_cnt;       // granted by the cache, not yet answered
    logic [c_CNT_W-1:0] r_drop;      // how many of r_cnt are stale
    logic               r_lerr;      // local error response pending

    logic               w_aligned;
    logic               w_cache_gnt;
    logic               w_lerr_gnt;
    logic               w_rsp_ack;   // cache response that retires an entry
    logic               w_cache_src;
    logic               w_lerr_src;
    logic               w_raw_valid;
    logic [DATA_W-1:0]  w_raw_data;
    logic               w_raw_err;
    logic               w_rsp_pending;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    generate
        if (c_OFF_W == 0) begin : g_align_none
            assign w_aligned = 1'b1;
        end else begin : g_align_chk
            assign w_aligned = (instr_addr_i[c_OFF_W-1:0] == '0);
        end
    endgenerate

    assign cache_req_o  = instr_req_i & w_aligned & ~flush_i & ~r_lerr & (r_cnt < c_MAX);
    assign cache_addr_o = instr_addr_i;
    assign w_cache_gnt  = cache_req_o & cache_gnt_i;

    // A misaligned fetch is only accepted once the cache side is drained, so
    // its local error can never collide with a cache response.
    assign w_lerr_gnt   = instr_req_i & ~w_aligned & (r_cnt == '0) & ~r_lerr & ~flush_i;
    assign instr_gnt_o  = w_cache_gnt | w_lerr_gnt;

    // ------------------------------------------------------------------
    // Raw response selection
    // ------------------------------------------------------------------
    assign w_rsp_ack   = cache_rvalid_i & (r_cnt != '0);
    assign w_cache_src = cache_rvalid_i & (r_drop == '0) & ~flush_i;
    assign w_lerr_src  = r_lerr & ~flush_i;
    assign w_raw_valid = w_cache_src | w_lerr_src;
    assign w_raw_data  = w_cache_src ? cache_rdata_i : '0;
    assign w_raw_err   = w_lerr_src | (w_cache_src & cache_rerror_i);

    // Track outstanding/stale counts and the local error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_drop <= '0;
            r_lerr <= 1'b0;
        end else begin
            // Saturates at zero if the cache answers with nothing in flight.
            r_cnt <= r_cnt + c_CNT_W'(w_cache_gnt) - c_CNT_W'(w_rsp_ack);
            if (flush_i) begin
                r_drop <= r_cnt - c_CNT_W'(w_rsp_ack);
                r_lerr <= 1'b0;
            end else begin
                r_drop <= r_drop - c_CNT_W'(cache_rvalid_i & (r_drop != '0));
                if (w_lerr_gnt) begin
                    r_lerr <= 1'b1;
                end else begin
                    r_lerr <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (REG_RSP) begin : g_reg_rsp
            logic              r_rsp_valid;
            logic [DATA_W-1:0] r_rsp_data;
            logic              r_rsp_err;

            // Register the raw response every cycle; a flush kills it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b0;
                end else begin
                    r_rsp_valid <= w_raw_valid & ~flush_i;
                    r_rsp_data  <= w_raw_data;
                    r_rsp_err   <= w_raw_err;
                end
            end

            assign instr_rvalid_o = r_rsp_valid;
            assign instr_rdata_o  = r_rsp_data;
            assign instr_err_o    = r_rsp_err;
            assign w_rsp_pending  = r_rsp_valid;
        end else begin : g_comb_rsp
            assign instr_rvalid_o = w_raw_valid;
            assign instr_rdata_o  = w_raw_data;
            assign instr_err_o    = w_raw_err;
            assign w_rsp_pending  = 1'b0;
        end
    endgenerate

    assign busy_o = (r_cnt != '0) | r_lerr | w_rsp_pending;

    // A cache response with nothing outstanding breaks the I$ protocol.
    a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cache_rvalid_i && (r_cnt == '0)));

endmodule
`default_nettype wire
